x2u_frame_tx: RTL and testbench

X2U_FRAME_TX -- requirements
Module: x2u_frame_tx

---
 rtl/x2u_frame_tx_pkg.sv | 28 ++
 rtl/x2u_frame_tx_if.sv | 30 +++
 rtl/x2u_frame_tx.sv | 112 +++++++++++
 tb/tb_x2u_frame_tx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/x2u_frame_tx_pkg.sv
// ------------------------------------------------------------------
// x2u_frame_tx_pkg -- shared UART/XINTF frame constants, FSM states
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package x2u_frame_tx_pkg;

  localparam int c_FBYTE_NUM_DEF = 22;     // X2U full-frame length
  localparam int c_FLUSH_CYC_DEF = 50000;  // 1 ms at 50 MHz
  localparam int c_U2X_FBYTE_NUM = 22;     // U2X direction frame length

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_LATCH   = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4,
    ST_DONE    = 3'd5
  } tx_state_t;

  function automatic logic [7:0] f_inc8(input logic [7:0] v);
    return v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/x2u_frame_tx_if.sv
// ------------------------------------------------------------------
// x2u_frame_tx_if -- FIFO2 read side and UART transmit handshake bundle
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface x2u_frame_tx_if;

  logic [7:0] fifo_cnt;
  logic [7:0] f2_buf_out;
  logic       f2_rd_en;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       frame_busy;
  logic       frame_done;

  modport master (
    input  fifo_cnt, f2_buf_out, tx_busy,
    output f2_rd_en, tx_start, tx_data, frame_busy, frame_done
  );

  modport slave (
    output fifo_cnt, f2_buf_out, tx_busy,
    input  f2_rd_en, tx_start, tx_data, frame_busy, frame_done
  );

endinterface

`default_nettype wire

// File: rtl/x2u_frame_tx.sv
// ------------------------------------------------------------------
// x2u_frame_tx -- drains FIFO2 into the UART transmitter in frames
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module x2u_frame_tx
  import x2u_frame_tx_pkg::*;
#(
  parameter int FBYTE_NUM = c_FBYTE_NUM_DEF,
  parameter int FLUSH_CYC = c_FLUSH_CYC_DEF
) (
  input  logic           clk50M,
  input  logic           rst_n,
  x2u_frame_tx_if.master io_bus
);

  localparam int              c_FW    = $clog2(FLUSH_CYC + 2);
  localparam logic [7:0]      c_FBYTE = 8'(FBYTE_NUM);
  localparam logic [c_FW-1:0] c_FLUSH = c_FW'(FLUSH_CYC);

  tx_state_t       r_state;
  tx_state_t       w_next;
  logic [7:0]      r_tx_data;
  logic [7:0]      r_len;
  logic [7:0]      r_byte_cnt;
  logic [7:0]      r_prev_cnt;
  logic [c_FW-1:0] r_flush;
  logic            r_wait_first;
  logic            w_full;
  logic            w_flush;
  logic            w_rd;
  logic            w_start;
  logic            w_tx_free;

  always_ff @(posedge clk50M) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_rd      = 1'b0;
    w_start   = 1'b0;
    w_tx_free = 1'b0;
    w_full    = (io_bus.fifo_cnt >= c_FBYTE);
    w_flush   = (io_bus.fifo_cnt != 8'd0) && !w_full && (r_flush == c_FLUSH);
    case (r_state)
      ST_IDLE:  if (w_full || w_flush) w_next = ST_READ;
      ST_READ: begin
        // An empty FIFO2 parks us here rather than issuing an underflow read
        if (io_bus.fifo_cnt != 8'd0) begin
          w_rd   = 1'b1;
          w_next = ST_LATCH;
        end
      end
      ST_LATCH: w_next = ST_SEND;
      ST_SEND: begin
        if (!io_bus.tx_busy) begin
          w_start = 1'b1;
          w_next  = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        // UART raises busy one cycle after tx_start, so the first cycle is skipped
        if (!r_wait_first && !io_bus.tx_busy) begin
          w_tx_free = 1'b1;
          w_next    = (f_inc8(r_byte_cnt) == r_len) ? ST_DONE : ST_READ;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk50M) begin
    if (!rst_n) begin
      r_tx_data    <= 8'h00;
      r_len        <= 8'h00;
      r_byte_cnt   <= 8'h00;
      r_prev_cnt   <= 8'h00;
      r_flush      <= '0;
      r_wait_first <= 1'b0;
    end else begin
      r_prev_cnt <= io_bus.fifo_cnt;
      if ((r_state != ST_IDLE) || (io_bus.fifo_cnt == 8'd0) ||
          (io_bus.fifo_cnt != r_prev_cnt))
        r_flush <= '0;
      else if (r_flush != c_FLUSH)
        r_flush <= r_flush + c_FW'(1);
      // Length is frozen at frame start; later FIFO growth waits for the next frame
      if ((r_state == ST_IDLE) && (w_next == ST_READ))
        r_len <= w_full ? c_FBYTE : io_bus.fifo_cnt;
      if (r_state == ST_LATCH)
        r_tx_data <= io_bus.f2_buf_out;
      r_wait_first <= w_start;
      if (w_tx_free)
        r_byte_cnt <= f_inc8(r_byte_cnt);
      else if (r_state == ST_DONE)
        r_byte_cnt <= 8'h00;
    end
  end

  assign io_bus.f2_rd_en   = w_rd;
  assign io_bus.tx_start   = w_start;
  assign io_bus.tx_data    = r_tx_data;
  assign io_bus.frame_busy = (r_state != ST_IDLE);
  assign io_bus.frame_done = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_x2u_frame_tx.sv
// ------------------------------------------------------------------
// tb_x2u_frame_tx -- scoreboard bench with FIFO2 and UART models
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_x2u_frame_tx;
  import x2u_frame_tx_pkg::*;

  localparam int FBYTE = c_FBYTE_NUM_DEF;
  localparam int FLUSH = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  x2u_frame_tx_if bif ();

  x2u_frame_tx #(.FBYTE_NUM(FBYTE), .FLUSH_CYC(FLUSH)) dut (
    .clk50M (clk),
    .rst_n  (rst_n),
    .io_bus (bif.master)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // FIFO2 model: pushes from stimulus, pops on f2_rd_en, data valid next cycle
  logic [7:0] push_data[$];
  logic [7:0] exp_q[$];
  logic [7:0] fifo_q[$];
  int         push_done  = 0;
  int         pops_total = 0;
  logic       gap        = 1'b0;
  logic [7:0] m_cnt      = 8'd0;
  logic [7:0] m_buf      = 8'd0;

  always @(posedge clk) begin
    if (bif.f2_rd_en && fifo_q.size() > 0) begin
      m_buf      <= fifo_q.pop_front();
      pops_total <= pops_total + 1;
    end
    for (int i = push_done; i < push_data.size(); i++) fifo_q.push_back(push_data[i]);
    push_done <= push_data.size();
    m_cnt     <= gap ? 8'd0 : 8'(fifo_q.size());
  end

  assign bif.fifo_cnt   = m_cnt;
  assign bif.f2_buf_out = m_buf;

  // UART model: busy for a random number of cycles per accepted byte
  int   busy_cnt   = 0;
  logic force_busy = 1'b0;

  always @(posedge clk) begin
    if (bif.tx_start && busy_cnt == 0) busy_cnt <= int'($urandom_range(4, 12));
    else if (busy_cnt > 0)             busy_cnt <= busy_cnt - 1;
  end

  assign bif.tx_busy = (busy_cnt != 0) || force_busy;

  // Monitor / scoreboard
  int         starts_total = 0;
  int         frames_done  = 0;
  int         frame_bytes  = 0;
  int         frame_reads  = 0;
  int         exp_len      = 0;
  int         run          = 0;
  logic       in_frame     = 1'b0;
  logic       pend_rst     = 1'b0;
  logic       prev_start   = 1'b0;
  logic       prev_rd      = 1'b0;
  logic       prev_done    = 1'b0;
  logic [7:0] cnt_prev     = 8'd0;

  always @(negedge clk) begin
    if (pend_rst) begin
      pend_rst = 1'b0;
      check("rst_f2_rd_en",   bif.f2_rd_en,   0);
      check("rst_tx_start",   bif.tx_start,   0);
      check("rst_frame_busy", bif.frame_busy, 0);
      check("rst_frame_done", bif.frame_done, 0);
      check("rst_tx_data",    bif.tx_data,    0);
      // Bytes pulled from FIFO2 but never sent are lost with the aborted frame
      while (starts_total < pops_total && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        starts_total++;
      end
      in_frame = 1'b0; frame_bytes = 0; frame_reads = 0; run = 0;
      prev_start = 1'b0; prev_rd = 1'b0; prev_done = 1'b0;
    end else if (rst_n) begin
      if (bif.frame_busy && !in_frame) begin
        in_frame    = 1'b1;
        frame_bytes = 0;
        frame_reads = 0;
        exp_len     = (cnt_prev >= FBYTE) ? FBYTE : int'(cnt_prev);
        if (cnt_prev < FBYTE)
          check("flush_wait_window", (run >= FLUSH && run <= FLUSH + 2), 1);
      end
      if (bif.tx_start) begin
        check("tx_start_while_busy", bif.tx_busy, 0);
        check("tx_start_single", prev_start, 0);
        check("tx_expected_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("tx_data", bif.tx_data, exp_q.pop_front());
        starts_total++;
        frame_bytes++;
      end
      if (bif.f2_rd_en) begin
        check("rd_no_underflow", bif.fifo_cnt == 8'd0, 0);
        check("rd_single", prev_rd, 0);
        frame_reads++;
      end
      if (bif.frame_done) begin
        check("frame_done_single", prev_done, 0);
        check("frame_len", frame_bytes, exp_len);
        check("frame_reads", frame_reads, exp_len);
        in_frame = 1'b0;
        frames_done++;
      end
      if (!bif.frame_busy && bif.fifo_cnt != 8'd0)
        run = (bif.fifo_cnt == cnt_prev) ? run + 1 : 1;
      else
        run = 0;
      prev_start = bif.tx_start;
      prev_rd    = bif.f2_rd_en;
      prev_done  = bif.frame_done;
    end
    if (!rst_n) pend_rst = 1'b1;
    cnt_prev = bif.fifo_cnt;
  end

  // Stimulus
  task automatic push_byte(input logic [7:0] b);
    push_data.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int k = 0;
    while (frames_done < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, frames_done >= target, 1);
  endtask

  task automatic wait_starts(input int target, input int budget, input string name);
    int k = 0;
    while (starts_total < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, starts_total >= target, 1);
  endtask

  initial begin
    int base;
    int lat;
    int cnt;
    bit seen;

    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_fifo_idle", bif.frame_busy, 0);

    // Full frame 0x01..0x16; trigger is the first sample showing the new count
    base = frames_done;
    for (int i = 1; i <= 22; i++) push_byte(8'(i));
    lat  = 0;
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (bif.tx_start) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    check("first_start_latency", lat, 4);
    wait_frames(base + 1, 1000, "full_frame_done");
    check("full_frame_all_sent", exp_q.size(), 0);

    // Short frame flushed after a quiet period
    base = frames_done;
    for (int i = 0; i < 5; i++) push_byte(8'($urandom));
    cnt = 0;
    repeat (FLUSH - 10) begin
      @(negedge clk);
      if (bif.frame_busy) cnt++;
    end
    check("no_early_flush", cnt, 0);
    wait_frames(base + 1, 500, "flush_frame_done");

    // Count keeps changing faster than the flush period
    base = frames_done;
    cnt  = 0;
    for (int i = 0; i < 8; i++) begin
      push_byte(8'($urandom));
      repeat (100) begin
        @(negedge clk);
        if (bif.frame_busy) cnt++;
      end
    end
    check("no_flush_while_changing", cnt, 0);
    wait_frames(base + 1, 600, "changing_frame_done");

    // UART busy held at frame start
    base       = frames_done;
    force_busy = 1'b1;
    for (int i = 0; i < 22; i++) push_byte(8'($urandom));
    cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (bif.tx_start) cnt++;
    end
    check("start_withheld_while_busy", cnt, 0);
    force_busy = 1'b0;
    wait_frames(base + 1, 1000, "busy_frame_done");

    // FIFO2 count forced to zero mid-frame
    base = frames_done;
    for (int i = 0; i < 22; i++) push_byte(8'($urandom));
    wait_starts(starts_total + 5, 500, "gap_reach_byte5");
    gap = 1'b1;
    @(negedge clk);
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (bif.f2_rd_en) cnt++;
    end
    gap = 1'b0;
    check("no_read_in_gap", cnt, 0);
    wait_frames(base + 1, 1000, "gap_frame_done");

    // 44 bytes give two back-to-back frames
    base = frames_done;
    for (int i = 0; i < 44; i++) push_byte(8'($urandom));
    wait_frames(base + 2, 2000, "two_frames_done");
    check("two_frames_exact", frames_done - base, 2);

    // Reset at byte 10, remainder goes out as a new frame
    for (int i = 0; i < 22; i++) push_byte(8'($urandom));
    wait_starts(starts_total + 10, 600, "reset_reach_byte10");
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    base = frames_done;
    wait_frames(base + 1, 1200, "post_reset_remainder_done");
    check("post_reset_all_sent", exp_q.size(), 0);
    base = frames_done;
    for (int i = 0; i < 22; i++) push_byte(8'($urandom));
    wait_frames(base + 1, 1000, "post_reset_clean_frame");

    repeat (5) @(negedge clk);
    check("final_scoreboard_empty", exp_q.size(), 0);
    check("final_fifo_empty", fifo_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
